// File: rtl/led_trail_pkg.sv
// Shared constants and helper functions for the comet-trail LED PWM stage.
package led_trail_pkg;

  // Widest Q_IN the one-hot checker accepts.
  localparam int unsigned MAX_POSITIONS = 64;

  function automatic int unsigned pwm_max_of(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  // Perceptual fade: square the brightness, but keep full scale fully on.
  function automatic int unsigned gamma_duty(input int unsigned b, input int unsigned w);
    int unsigned pmax;
    pmax = pwm_max_of(w);
    if (b == pmax) return pmax;
    return (b * b) >> w;
  endfunction

  function automatic logic is_onehot(input logic [MAX_POSITIONS-1:0] v);
    return (v != '0) && ((v & (v - 64'd1)) == '0);
  endfunction

endpackage

// File: rtl/led_pwm_cell.sv
// One LED: brightness register with load/decay, optional gamma (LED_TRAIL_GAMMA_EN)
// and the registered PWM compare.
module led_pwm_cell
  import led_trail_pkg::*;
#(
  parameter int unsigned PWM_W    = 4,
  parameter int unsigned DECAY_SH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             load,
  input  logic [PWM_W-1:0] pwm_cnt,
  output logic             led
);

  localparam logic [PWM_W-1:0] BrightMax = PWM_W'(pwm_max_of(PWM_W));

  logic [PWM_W-1:0] b_q, b_d, duty;

  always_comb begin
    b_d = b_q;
    if (load) begin
      b_d = BrightMax;
    end else if (ena) begin
      b_d = b_q >> DECAY_SH;
    end
  end

`ifdef LED_TRAIL_GAMMA_EN
  assign duty = PWM_W'(gamma_duty(32'(b_q), PWM_W));
`else
  assign duty = b_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q <= '0;
      led <= 1'b0;
    end else begin
      b_q <= b_d;
      led <= (duty > pwm_cnt);
    end
  end

endmodule

// File: rtl/led_trail_pwm.sv
// Comet-trail LED driver behind the bouncing one-hot shifter: PWM counter, sweep
// counter, one-hot error flag and N LED cells. Gamma fade via LED_TRAIL_GAMMA_EN.
module led_trail_pwm
  import led_trail_pkg::*;
#(
  parameter int unsigned N        = 8,
  parameter int unsigned PWM_W    = 4,
  parameter int unsigned DECAY_SH = 1,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             CLK,
  input  logic             RSTna,
  input  logic             ENA,
  input  logic             CLR,
  input  logic [N-1:0]     Q_IN,
  input  logic             TC_IN,
  output logic [N-1:0]     LED,
  output logic [CNT_W-1:0] SWEEPS,
  output logic             ERR
);

  // Counter runs 0..PWM_MAX-1 so a period is exactly PWM_MAX cycles.
  localparam logic [PWM_W-1:0] CntLast = PWM_W'(pwm_max_of(PWM_W) - 32'd1);

  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [CNT_W-1:0] sweeps_q, sweeps_d;
  logic             err_q, err_d;
  logic             q_ok;

  assign q_ok = is_onehot(MAX_POSITIONS'(Q_IN));

  always_comb begin
    pwm_cnt_d = (pwm_cnt_q == CntLast) ? '0 : pwm_cnt_q + 1'b1;

    sweeps_d = sweeps_q;
    if (CLR) begin
      sweeps_d = '0;
    end else if (TC_IN && (sweeps_q != '1)) begin
      sweeps_d = sweeps_q + 1'b1;
    end

    err_d = err_q;
    if (CLR) begin
      err_d = 1'b0;
    end else if (!q_ok) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTna) begin
    if (!RSTna) begin
      pwm_cnt_q <= '0;
      sweeps_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      sweeps_q  <= sweeps_d;
      err_q     <= err_d;
    end
  end

  assign SWEEPS = sweeps_q;
  assign ERR    = err_q;

  for (genvar i = 0; i < N; i++) begin : g_cell
    led_pwm_cell #(
      .PWM_W   (PWM_W),
      .DECAY_SH(DECAY_SH)
    ) u_cell (
      .clk    (CLK),
      .rst_n  (RSTna),
      .ena    (ENA),
      .load   (Q_IN[i]),
      .pwm_cnt(pwm_cnt_q),
      .led    (LED[i])
    );
  end

endmodule

// File: tb/tb_led_trail_pwm.sv
// Bench for led_trail_pwm: per-cycle scoreboard plus vector table and hand sequences.
module tb_led_trail_pwm;

  localparam int N     = 8;
  localparam int PWM_W = 4;
  localparam int CNT_W = 4;
  localparam int PMAX  = 15;
  localparam int SMAX  = 15;

  logic             CLK = 1'b0;
  logic             RSTna = 1'b0;
  logic             ENA = 1'b0;
  logic             CLR = 1'b0;
  logic             TC_IN = 1'b0;
  logic [N-1:0]     Q_IN = '0;
  logic [N-1:0]     LED;
  logic [CNT_W-1:0] SWEEPS;
  logic             ERR;

  led_trail_pwm #(
    .N       (N),
    .PWM_W   (PWM_W),
    .DECAY_SH(1),
    .CNT_W   (CNT_W)
  ) dut (
    .CLK   (CLK),
    .RSTna (RSTna),
    .ENA   (ENA),
    .CLR   (CLR),
    .Q_IN  (Q_IN),
    .TC_IN (TC_IN),
    .LED   (LED),
    .SWEEPS(SWEEPS),
    .ERR   (ERR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [N-1:0]     led;
    logic [CNT_W-1:0] sw;
    logic             err;
  } obs_t;

  obs_t sb_q[$];

  // Reference model state
  int   mb[N];
  int   mcnt;
  obs_t mo;

  typedef struct {
    logic       ena;
    logic       clr;
    logic       tc;
    logic [7:0] q;
    int         exp_sw;
    int         exp_err;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int mduty(input int b);
`ifdef LED_TRAIL_GAMMA_EN
    if (b == PMAX) return PMAX;
    return (b * b) / 16;
`else
    return b;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) mb[i] = 0;
    mcnt = 0;
    mo   = '0;
    sb_q.delete();
  endtask

  // Drive one cycle from a negedge, predict the post-edge outputs, compare at next negedge.
  task automatic step(input logic ena, input logic clr, input logic tc, input logic [N-1:0] q);
    obs_t got, exp;
    ENA   = ena;
    CLR   = clr;
    TC_IN = tc;
    Q_IN  = q;
    for (int i = 0; i < N; i++) mo.led[i] = (mduty(mb[i]) > mcnt);
    for (int i = 0; i < N; i++) begin
      if (q[i]) mb[i] = PMAX;
      else if (ena) mb[i] = mb[i] / 2;
    end
    mcnt = (mcnt == PMAX - 1) ? 0 : mcnt + 1;
    if (clr) mo.sw = '0;
    else if (tc && (int'(mo.sw) < SMAX)) mo.sw = mo.sw + 1'b1;
    if (clr) mo.err = 1'b0;
    else if ($countones(q) != 1) mo.err = 1'b1;
    sb_q.push_back(mo);
    @(posedge CLK);
    @(negedge CLK);
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      exp = sb_q.pop_front();
      got = {LED, SWEEPS, ERR};
      check("sb_outputs", 32'(got), 32'(exp));
    end
  endtask

  // Hold q for n cycles (ENA=0) and count how often LED[7] is high.
  task automatic count_led7(input int n, input logic [N-1:0] q, output int hi);
    hi = 0;
    for (int k = 0; k < n; k++) begin
      step(1'b0, 1'b0, 1'b0, q);
      if (LED[7]) hi++;
    end
  endtask

  int hi;
  int bad;

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 8'h01, 0, 0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 8'h01, 1, 0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 8'h02, 2, 0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 8'h04, 3, 0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'h04, 3, 0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 8'h04, 0, 0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'h81, 0, 1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'h01, 0, 1};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 8'h01, 1, 1};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h01, 0, 0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 0, 1};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 8'hC0, 0, 1};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 8'h01, 0, 0};

    // Reset state
    #2;
    check("rst_led", 32'(LED), 32'd0);
    check("rst_sweeps", 32'(SWEEPS), 32'd0);
    check("rst_err", 32'(ERR), 32'd0);
    @(negedge CLK);
    RSTna = 1'b1;
    model_reset();

    // Full on: LED[7] solid from the second edge
    step(1'b0, 1'b1, 1'b0, 8'h80);
    check("full_first_edge", 32'(LED), 32'h00);
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      step(1'b0, 1'b0, 1'b0, 8'h80);
      if (LED !== 8'h80) bad++;
    end
    check("full_on_window", 32'(bad), 32'd0);

    // Decay 15 -> 7 -> 3 -> 1 -> 0, one ENA tick per step
    step(1'b1, 1'b0, 1'b0, 8'h40);
    step(1'b0, 1'b0, 1'b0, 8'h40);
    count_led7(15, 8'h40, hi);
`ifdef LED_TRAIL_GAMMA_EN
    check("duty_b7", 32'(hi), 32'd3);
`else
    check("duty_b7", 32'(hi), 32'd7);
`endif
    step(1'b1, 1'b0, 1'b0, 8'h20);
    step(1'b0, 1'b0, 1'b0, 8'h20);
    count_led7(15, 8'h20, hi);
`ifdef LED_TRAIL_GAMMA_EN
    check("duty_b3", 32'(hi), 32'd0);
`else
    check("duty_b3", 32'(hi), 32'd3);
`endif
    step(1'b1, 1'b0, 1'b0, 8'h10);
    step(1'b0, 1'b0, 1'b0, 8'h10);
    count_led7(15, 8'h10, hi);
`ifdef LED_TRAIL_GAMMA_EN
    check("duty_b1", 32'(hi), 32'd0);
`else
    check("duty_b1", 32'(hi), 32'd1);
`endif
    step(1'b1, 1'b0, 1'b0, 8'h08);
    step(1'b0, 1'b0, 1'b0, 8'h08);
    count_led7(15, 8'h08, hi);
    check("duty_b0", 32'(hi), 32'd0);

    // Sweep counter and error flag vectors
    for (int v = 0; v < 14; v++) begin
      step(vecs[v].ena, vecs[v].clr, vecs[v].tc, vecs[v].q);
      check($sformatf("vec%0d_sweeps", v), 32'(SWEEPS), 32'(vecs[v].exp_sw));
      check($sformatf("vec%0d_err", v), 32'(ERR), 32'(vecs[v].exp_err));
    end

    // Saturation, then CLR beats a simultaneous TC_IN
    for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 1'b1, 8'h01);
    check("sweeps_sat", 32'(SWEEPS), 32'd15);
    step(1'b0, 1'b1, 1'b1, 8'h01);
    check("sweeps_clr_tc", 32'(SWEEPS), 32'd0);

    // Mid-cycle asynchronous reset with state everywhere non-zero
    step(1'b0, 1'b0, 1'b1, 8'h00);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, 8'h80);
    @(posedge CLK);
    #1 RSTna = 1'b0;
    #1;
    check("async_rst_led", 32'(LED), 32'd0);
    check("async_rst_sweeps", 32'(SWEEPS), 32'd0);
    check("async_rst_err", 32'(ERR), 32'd0);
    #1 RSTna = 1'b1;
    @(negedge CLK);
    model_reset();
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 1'b0, 8'h00);
      if (LED !== 8'h00) bad++;
    end
    check("post_rst_dark", 32'(bad), 32'd0);
    step(1'b0, 1'b1, 1'b0, 8'h80);
    check("post_rst_load_lag", 32'(LED), 32'h00);
    step(1'b0, 1'b0, 1'b0, 8'h80);
    check("post_rst_load_on", 32'(LED), 32'h80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_trail_pwm.md
Name: led_trail_pwm

Overview:
- Display stage directly downstream of the bouncing one-hot shift register.
- Consumes its one-hot position Q and its terminal-count pulse TC.
- Drives N LEDs with a "comet trail": the active LED is at full brightness and previously active LEDs fade geometrically, rendered by PWM.
- Also counts completed sweeps via TC and flags malformed (non-one-hot) position input.

Parameters:
- N, 8, number of positions/LEDs; must match the upstream shift register width.
- PWM_W, 4, brightness resolution in bits; PWM_MAX = 2^PWM_W - 1.
- DECAY_SH, 1, right-shift applied to a fading LED's brightness per step tick (1 = halve).
- CNT_W, 8, width of the sweep counter.

Ports:
- CLK  in  1  system clock, rising edge.
- RSTna  in  1  asynchronous active-low reset.
- ENA  in  1  step tick; the same synchronous enable that advances the upstream shift register.
- CLR  in  1  synchronous clear of SWEEPS and ERR, active high.
- Q_IN  in  N  one-hot position from upstream (registered there).
- TC_IN  in  1  one-cycle pulse from upstream when the position reaches the LSB.
- LED  out  N  PWM-modulated LED drive, registered, active high.
- SWEEPS  out  CNT_W  saturating count of TC_IN pulses.
- ERR  out  1  sticky flag: Q_IN was seen with popcount != 1.

Behaviour:
- Reset (RSTna=0, asynchronous): all brightness regs B[i]=0, pwm_cnt=0, LED=0, SWEEPS=0, ERR=0. Applies immediately, including mid-PWM-period or mid-sweep.
- Brightness update at each rising edge, per bit i, in priority order:
  - Q_IN[i]=1: B[i] <= PWM_MAX, every cycle regardless of ENA.
  - Otherwise, ENA=1: B[i] <= B[i] >> DECAY_SH.
  - Otherwise: hold.
  - Decay reaches 0 and stays at 0; there is no underflow.
- PWM counter: free-running pwm_cnt counts 0..PWM_MAX-1, then wraps to 0. Period is PWM_MAX cycles. It is not gated by ENA.
- LED drive: LED[i] <= (duty[i] > pwm_cnt), using current register values.
  - Without the optional feature, duty[i] = B[i].
  - duty=PWM_MAX gives always on; duty=0 gives always off; duty=k gives on for exactly k of every PWM_MAX cycles.
  - Latency from a Q_IN change to LED reflecting full brightness is 2 edges: B loads, then LED registers.
- Sweep counter:
  - Each cycle with TC_IN=1 increments SWEEPS by 1, independent of ENA.
  - SWEEPS saturates at 2^CNT_W-1 and does not wrap.
  - CLR=1 sets SWEEPS to 0. CLR takes priority over a simultaneous TC_IN.
- Error flag:
  - If Q_IN has zero bits set or more than one bit set at a rising edge, ERR <= 1.
  - ERR is sticky until CLR or reset. CLR and a simultaneous bad Q_IN give ERR=0 (CLR wins).
  - Brightness updates still apply bitwise on bad input; multiple set bits all load PWM_MAX.
- There is no handshake. Q_IN and TC_IN are assumed synchronous to CLK, since upstream is on the same clock.

Optional Feature:
- Macro: LED_TRAIL_GAMMA_EN.
- Defined: duty[i] = PWM_MAX when B[i]=PWM_MAX, else (B[i]*B[i]) >> PWM_W. The product is 2*PWM_W bits wide. This gives a perceptual fade.
- Undefined: duty[i] = B[i], linear, and no multiplier is synthesized.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package led_trail_pkg holds:
  - the PWM_MAX computation as a constant function of PWM_W;
  - a gamma function (B -> duty);
  - a popcount-is-one helper function.
- Natural sub-module: led_pwm_cell, instantiated N times via generate. Each holds one brightness register, its decay/load logic, the optional gamma stage, and the output compare flop.
- The top level keeps pwm_cnt, SWEEPS, ERR and the generate loop.

Test Plan:
- Reset: after running, drop RSTna for less than one clock period mid-cycle. LED=0, SWEEPS=0 and ERR=0 immediately, without waiting for a clock edge. After release, LED stays 0 until Q_IN loads a brightness.
- Full on (N=8, PWM_W=4, defaults): Q_IN=8'h80, ENA=0. From the 2nd edge on, LED[7]=1 on every cycle over a 30-cycle window and LED[6:0]=0.
- Decay: Q_IN steps 80->40->20->10->08 with one ENA tick per step. B[7] goes 15, 7, 3, 1, 0. While B[7]=7, LED[7] is high exactly 7 of 15 cycles per PWM period.
- Sweeps (CNT_W=4): 3 TC_IN pulses give SWEEPS=3. 20 pulses give SWEEPS=15 (saturated). CLR and TC_IN in the same cycle give SWEEPS=0.
- Error: Q_IN=8'h81 for one cycle, then 8'h01. ERR=1 from the next edge and remains 1. CLR=1 for one cycle clears it to 0. Q_IN=8'h00 sets it again.
- Gamma (LED_TRAIL_GAMMA_EN defined): with B[7]=7, LED[7] is high 3 of 15 cycles. With B[7]=15, it is high 15 of 15 cycles.
